// File: rtl/led_mode_pkg.sv
// Shared types and constants for the LED mode controller: mode encodings,
// initial patterns, widths and the per-tick pattern step.
package led_mode_pkg;

    localparam int MODE_W   = 2;
    localparam int LED_W    = 4;
    localparam int NUM_KEYS = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_FLOW  = 2'd2,
        MODE_COUNT = 2'd3
    } mode_e;

    localparam logic [LED_W-1:0] PAT_OFF   = 4'b0000;
    localparam logic [LED_W-1:0] PAT_BLINK = 4'b1111;
    localparam logic [LED_W-1:0] PAT_FLOW  = 4'b0001;
    localparam logic [LED_W-1:0] PAT_COUNT = 4'b0000;

    function automatic logic [LED_W-1:0] init_pattern(input mode_e m);
        logic [LED_W-1:0] p;
        case (m)
            MODE_BLINK: p = PAT_BLINK;
            MODE_FLOW:  p = PAT_FLOW;
            MODE_COUNT: p = PAT_COUNT;
            default:    p = PAT_OFF;
        endcase
        return p;
    endfunction

    function automatic logic [LED_W-1:0] next_pattern(input mode_e m,
                                                      input logic [LED_W-1:0] cur);
        logic [LED_W-1:0] p;
        case (m)
            MODE_BLINK: p = ~cur;
            MODE_FLOW:  p = {cur[LED_W-2:0], cur[LED_W-1]};
            MODE_COUNT: p = cur + 1'b1;
            default:    p = PAT_OFF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key lane: 2-flop synchronizer, counting debouncer and a registered
// one-cycle pulse on each debounced 0->1 transition.
module key_debounce #(
    parameter int DEB_CNT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_lvl,
    output logic key_press
);

    localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT - 1);

    logic             sync1_q, sync2_q;
    logic             lvl_q, lvl_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only survives while every sample disagrees with the
    // accepted level, so DEB_CNT consecutive samples are needed to flip it.
    always_comb begin
        cnt_d   = '0;
        lvl_d   = lvl_q;
        press_d = 1'b0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CNT_MAX) begin
                lvl_d   = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_lvl   = lvl_q;
    assign key_press = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Four-key LED mode controller: debounced key presses select OFF/BLINK/FLOW/COUNT
// and a tick counter steps the pattern. Define KEY_ROUND_ROBIN_EN for round-robin arbitration.
module led_mode_ctrl
    import led_mode_pkg::*;
#(
    parameter int DEB_CNT  = 1000000,
    parameter int TICK_CNT = 12500000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    output logic [LED_W-1:0]    led,
    output logic [MODE_W-1:0]   mode,
    output logic [NUM_KEYS-1:0] grant
);

    localparam int TCNT_W = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam logic [TCNT_W-1:0] TICK_MAX = TCNT_W'(TICK_CNT - 1);

    logic [NUM_KEYS-1:0] key_lvl;
    logic [NUM_KEYS-1:0] key_press;
    logic                unused_lvl;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_in    (key[g]),
            .key_lvl   (key_lvl[g]),
            .key_press (key_press[g])
        );
    end

    assign unused_lvl = ^key_lvl;

    logic       sel_valid;
    logic [1:0] sel_idx;

`ifdef KEY_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;

    // ptr_q holds the last granted index; the search begins just after it.
    always_comb begin
        logic [1:0] idx;
        sel_valid = 1'b0;
        sel_idx   = '0;
        idx       = '0;
        for (int i = 1; i <= NUM_KEYS; i++) begin
            idx = ptr_q + 2'(i);
            if (!sel_valid && key_press[idx]) begin
                sel_valid = 1'b1;
                sel_idx   = idx;
            end
        end
        ptr_d = sel_valid ? sel_idx : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        sel_valid = |key_press;
        sel_idx   = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_press[i]) sel_idx = 2'(i);
        end
    end
`endif

    mode_e               mode_q, mode_d;
    logic [LED_W-1:0]    led_q, led_d;
    logic [NUM_KEYS-1:0] grant_q, grant_d;
    logic [TCNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic                tick;

    assign tick = (tick_cnt_q == TICK_MAX);

    // A grant restarts the selected mode and swallows any coincident tick.
    always_comb begin
        grant_d    = '0;
        mode_d     = mode_q;
        led_d      = led_q;
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (sel_valid) begin
            grant_d[sel_idx] = 1'b1;
            mode_d           = mode_e'(sel_idx);
            led_d            = init_pattern(mode_e'(sel_idx));
            tick_cnt_d       = '0;
        end else if (tick) begin
            tick_cnt_d = '0;
            led_d      = next_pattern(mode_q, led_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_OFF;
            led_q      <= '0;
            grant_q    <= '0;
            tick_cnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            led_q      <= led_d;
            grant_q    <= grant_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign led   = led_q;
    assign mode  = mode_q;
    assign grant = grant_q;

endmodule
